mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
Shares the single instruction/data memory read port between two requesters: the fetch stage (port F) and the load path of the memory stage (port D). Sits between fetch / load unit and the memory model/bus. Uses the same enable/addr/ready/data read handshake on every side. One transaction is outstanding at a time. Ties are resolved round-robin, and a fetch flush can discard an in-flight fetch response.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, read data width in bits
TIMEOUT, 64, cycles before an unanswered request is aborted (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
f_rd_enable  input  1  fetch read request, held high until f_rd_ready or flush
f_rd_addr  input  ADDR_W  fetch address, stable while f_rd_enable high
f_rd_ready  output  1  one-cycle pulse: f_rd_data valid
f_rd_data  output  DATA_W  fetch read data
f_flush  input  1  fetch flush; kills the pending/in-flight fetch
d_rd_enable  input  1  data read request, held high until d_rd_ready
d_rd_addr  input  ADDR_W  data address
d_rd_ready  output  1  one-cycle pulse: d_rd_data valid
d_rd_data  output  DATA_W  data read data
mem_rd_enable  output  1  memory read request
mem_rd_addr  output  ADDR_W  memory read address
mem_rd_ready  input  1  memory response strobe, one cycle
mem_rd_data  input  DATA_W  memory data, valid with mem_rd_ready
busy  output  1  high whenever state is not IDLE
owner  output  1  0 = fetch granted, 1 = data granted; meaningful only while busy

Behaviour:
- Reset: state IDLE, mem_rd_enable=0, mem_rd_addr=0, owner=0, last_grant=F, drop=0. f_rd_ready and d_rd_ready are 0 in all IDLE cycles.
- States: IDLE, GNT_F, GNT_D.
  - mem_rd_enable, mem_rd_addr and owner are registered.
  - mem_rd_enable=1 exactly in GNT_F and GNT_D.
- IDLE arbitration on a rising edge:
  - Only d_rd_enable high -> GNT_D.
  - Only f_rd_enable high, with f_flush low -> GNT_F.
  - Both high -> grant the port not equal to last_grant; reset value makes D win the first tie.
  - The address is latched into mem_rd_addr and last_grant is updated.
  - f_rd_enable with f_flush high in the same cycle is not granted.
- Completion in GNT_x on the cycle mem_rd_ready=1:
  - x_rd_ready=1 combinationally in that same cycle, with x_rd_data=mem_rd_data.
  - Next state is IDLE.
- f_rd_data and d_rd_data are wired straight to mem_rd_data. Only the ready strobes are gated.
- Mandatory turnaround: at least one IDLE cycle with mem_rd_enable=0 between transactions, so every transaction shows a fresh rising edge of mem_rd_enable.
  - Best case, request in cycle N: enable high in N+1, ready no earlier than N+1, enable low in the cycle after ready.
- Flush:
  - f_flush in GNT_F sets drop. The memory transaction is not aborted; the arbiter stays in GNT_F until mem_rd_ready.
  - f_rd_ready is suppressed for that response and drop clears.
  - f_flush in the completion cycle itself also suppresses f_rd_ready.
  - f_flush has no effect in GNT_D.
- mem_rd_ready in IDLE is ignored.
- Reset asserted mid-transaction: return to reset state next edge. A subsequent stale mem_rd_ready is ignored.
- Requester dropping x_rd_enable while granted (other than a flushed fetch) is a protocol violation; behaviour is undefined.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- When defined:
  - Adds outputs f_rd_err and d_rd_err (1 bit each, reset 0).
  - Adds a cycle counter cleared on grant and incremented each GNT_x cycle without mem_rd_ready.
  - When the counter reaches TIMEOUT-1 with no ready: pulse x_rd_err for one cycle (suppressed for a dropped fetch), do not assert x_rd_ready, go to IDLE.
  - A late mem_rd_ready arriving while IDLE is ignored.
- When undefined: no counter and no err ports; the arbiter waits indefinitely for mem_rd_ready.

Test Plan:
- Single fetch:
  - Stimulus: f_rd_enable=1 with addr 0x10; memory answers 0x8010 two cycles after enable rises.
  - Required: mem_rd_addr=0x10, f_rd_ready one pulse with data 0x8010, busy falls the next cycle.
- Simultaneous requests after reset:
  - Stimulus: F addr 0x20 and D addr 0x100 held high together.
  - Required: D served first, then F; exactly one turnaround cycle with mem_rd_enable=0 between them.
- Continuous contention:
  - Stimulus: both requesters re-request immediately after every ready, for 6 transactions.
  - Required: grant order is D, F, D, F, D, F.
- Flush in flight:
  - Stimulus: f_flush pulsed 1 cycle after the GNT_F grant.
  - Required: mem_rd_enable stays high until mem_rd_ready, f_rd_ready stays 0, then a pending D request is granted.
- Reset mid-transaction:
  - Stimulus: reset during GNT_D, then a stray mem_rd_ready.
  - Required: mem_rd_enable=0, d_rd_ready=0, busy=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8:
  - Stimulus: memory never answers a D request.
  - Required: d_rd_err pulses on the 8th granted cycle, d_rd_ready stays 0, state returns to IDLE.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory read port between fetch (F) and load (D).
// Optional request timeout with error pulses is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_rd_enable,
    input  logic [ADDR_W-1:0] f_rd_addr,
    output logic              f_rd_ready,
    output logic [DATA_W-1:0] f_rd_data,
    input  logic              f_flush,
    input  logic              d_rd_enable,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_ready,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              mem_rd_enable,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ready,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              owner
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic              f_rd_err,
    output logic              d_rd_err
`endif
);

    typedef enum logic [1:0] {IDLE, GNT_F, GNT_D} state_e;

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;   // 0 = fetch granted last, 1 = data granted last
    logic              drop_q, drop_d;
    logic              f_req;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_rd_arbiter: TIMEOUT must be at least 2");
    end

    // A flushed fetch in the same cycle is never a candidate for the grant.
    assign f_req = f_rd_enable && !f_flush;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    assign cnt_d       = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    assign timeout_hit = (state_q != IDLE) && !mem_rd_ready
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        addr_d     = addr_q;
        owner_d    = owner_q;
        last_d     = last_q;
        drop_d     = drop_q;
        f_rd_ready = 1'b0;
        d_rd_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        f_rd_err   = 1'b0;
        d_rd_err   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (d_rd_enable && (!f_req || !last_q)) begin
                    state_d = GNT_D;
                    en_d    = 1'b1;
                    addr_d  = d_rd_addr;
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                end else if (f_req) begin
                    state_d = GNT_F;
                    en_d    = 1'b1;
                    addr_d  = f_rd_addr;
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            GNT_F: begin
                // The bus transaction always runs to completion; a flush only hides the response.
                if (mem_rd_ready) begin
                    f_rd_ready = !drop_q && !f_flush;
                    state_d    = IDLE;
                    en_d       = 1'b0;
                    drop_d     = 1'b0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    f_rd_err = !drop_q && !f_flush;
                    state_d  = IDLE;
                    en_d     = 1'b0;
                    drop_d   = 1'b0;
                end
`endif
                else if (f_flush) begin
                    drop_d = 1'b1;
                end
            end
            GNT_D: begin
                if (mem_rd_ready) begin
                    d_rd_ready = 1'b1;
                    state_d    = IDLE;
                    en_d       = 1'b0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    d_rd_err = 1'b1;
                    state_d  = IDLE;
                    en_d     = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            addr_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign mem_rd_enable = en_q;
    assign mem_rd_addr   = addr_q;
    assign owner         = owner_q;
    assign busy          = (state_q != IDLE);
    assign f_rd_data     = mem_rd_data;
    assign d_rd_data     = mem_rd_data;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the arbitration rules (timeout checks with MEM_ARB_TIMEOUT_EN).
module tb_mem_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, f_rd_enable, f_flush, d_rd_enable, mem_rd_ready;
    logic [AW-1:0] f_rd_addr, d_rd_addr, mem_rd_addr;
    logic [DW-1:0] mem_rd_data, f_rd_data, d_rd_data;
    logic          f_rd_ready, d_rd_ready, mem_rd_enable, busy, owner;
`ifdef MEM_ARB_TIMEOUT_EN
    logic          f_rd_err, d_rd_err;
`endif

    mem_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .f_rd_enable(f_rd_enable), .f_rd_addr(f_rd_addr), .f_rd_ready(f_rd_ready),
        .f_rd_data(f_rd_data), .f_flush(f_flush),
        .d_rd_enable(d_rd_enable), .d_rd_addr(d_rd_addr), .d_rd_ready(d_rd_ready),
        .d_rd_data(d_rd_data),
        .mem_rd_enable(mem_rd_enable), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
        .busy(busy), .owner(owner)
`ifdef MEM_ARB_TIMEOUT_EN
        , .f_rd_err(f_rd_err), .d_rd_err(d_rd_err)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: who holds the port (0 none, 1 F, 2 D), who won last, cycles into the grant.
    int            m_who = 0, m_last = 1, m_g = 0, cur_lat = 0, lat_fix = -1;
    bit            m_drop = 0;
    logic [AW-1:0] m_addr = '0;
    bit            flush_pend = 0, rst_pend = 0, stray_pend = 0;
    logic [AW-1:0] f_q[$], d_q[$];
    int            g_log[$];
    logic [DW-1:0] last_f_data = '0;
    int            f_obs = 0, d_obs = 0, err_obs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit fr, dr, to_hit, fq;
        int win;
        reset       = rst_pend;    rst_pend = 0;
        f_rd_enable = (f_q.size() > 0);
        f_rd_addr   = (f_q.size() > 0) ? f_q[0] : '0;
        d_rd_enable = (d_q.size() > 0);
        d_rd_addr   = (d_q.size() > 0) ? d_q[0] : '0;
        f_flush     = flush_pend;  flush_pend = 0;
        if (m_who != 0 && m_g == cur_lat) begin
            mem_rd_ready = 1'b1;
            mem_rd_data  = m_addr + 32'h8000;
        end else begin
            mem_rd_ready = stray_pend;
            mem_rd_data  = $urandom;
        end
        stray_pend = 0;
        @(negedge clk);
        to_hit = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_hit = (m_who != 0) && !mem_rd_ready && (m_g == TO - 1);
`endif
        fr = (m_who == 1) && mem_rd_ready && !m_drop && !f_flush;
        dr = (m_who == 2) && mem_rd_ready;
        chk("busy", busy, m_who != 0);
        chk("mem_en", mem_rd_enable, m_who != 0);
        if (m_who != 0) begin
            chk("mem_addr", mem_rd_addr, m_addr);
            chk("owner", owner, m_who == 2);
        end
        chk("f_ready", f_rd_ready, fr);
        chk("d_ready", d_rd_ready, dr);
        if (fr) begin chk("f_data", f_rd_data, mem_rd_data); last_f_data = f_rd_data; end
        if (dr) chk("d_data", d_rd_data, mem_rd_data);
        if (f_rd_ready === 1'b1) f_obs++;
        if (d_rd_ready === 1'b1) d_obs++;
`ifdef MEM_ARB_TIMEOUT_EN
        chk("f_err", f_rd_err, to_hit && m_who == 1 && !m_drop && !f_flush);
        chk("d_err", d_rd_err, to_hit && m_who == 2);
        if (d_rd_err === 1'b1 || f_rd_err === 1'b1) err_obs++;
`endif
        // Requesters retire on response, error or flush.
        if ((fr || (to_hit && m_who == 1) || f_flush) && f_q.size() > 0) void'(f_q.pop_front());
        if ((dr || (to_hit && m_who == 2)) && d_q.size() > 0) void'(d_q.pop_front());
        if (reset) begin
            m_who = 0; m_last = 1; m_drop = 0; m_addr = '0;
            f_q.delete(); d_q.delete();
        end else if (m_who == 0) begin
            fq  = f_rd_enable && !f_flush;
            win = 0;
            if (fq && d_rd_enable) win = (m_last == 1) ? 2 : 1;
            else if (d_rd_enable)  win = 2;
            else if (fq)           win = 1;
            if (win != 0) begin
                m_who = win; m_last = win; m_g = 0; m_drop = 0;
                m_addr  = (win == 2) ? d_rd_addr : f_rd_addr;
                cur_lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
                g_log.push_back(win);
            end
        end else if (mem_rd_ready || to_hit) begin
            m_who = 0; m_drop = 0;
        end else begin
            m_g++;
            if (m_who == 1 && f_flush) m_drop = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (f_q.size() == 0 && d_q.size() == 0 && m_who == 0) break;
            cycle();
        end
        cycle();
    endtask

    task automatic chk_log(input string tag, input int n, input int first_is_d);
        chk({tag, "_count"}, g_log.size(), n);
        for (int i = 0; i < n && i < g_log.size(); i++)
            chk($sformatf("%s_grant%0d", tag, i), g_log[i], ((i % 2 == 0) == (first_is_d != 0)) ? 2 : 1);
    endtask

    initial begin
        int f0, d0;
        reset = 1'b1; f_rd_enable = 0; d_rd_enable = 0; f_flush = 0; mem_rd_ready = 0;
        f_rd_addr = '0; d_rd_addr = '0; mem_rd_data = '0;

        rst_pend = 1; cycle(); rst_pend = 1; cycle(); cycle();
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_owner", owner, 0);

        // Single fetch, memory answers two cycles after enable rises.
        g_log.delete(); lat_fix = 2; f_q.push_back(32'h10);
        drain(20);
        chk("single_grants", g_log.size(), 1);
        chk("single_data", last_f_data, 32'h8010);

        // Simultaneous requests right after reset: D first.
        rst_pend = 1; cycle(); g_log.delete(); lat_fix = 1;
        f_q.push_back(32'h20); d_q.push_back(32'h100);
        drain(30);
        chk_log("simul", 2, 1);

        // Continuous contention: alternate D, F, D, F, D, F.
        rst_pend = 1; cycle(); g_log.delete(); lat_fix = 0;
        for (int i = 0; i < 3; i++) begin
            f_q.push_back(32'h1000 + 32'(i * 4));
            d_q.push_back(32'h2000 + 32'(i * 4));
        end
        drain(40);
        chk_log("contend", 6, 1);

        // Flush during an in-flight fetch, with a data request pending behind it.
        g_log.delete(); lat_fix = 4; f0 = f_obs;
        f_q.push_back(32'h40);
        for (int i = 0; i < 10 && m_who != 1; i++) cycle();
        cycle();
        d_q.push_back(32'h200); flush_pend = 1; cycle();
        drain(30);
        chk("flush_f_ready", f_obs - f0, 0);
        chk_log("flush", 2, 0);

        // Reset in the middle of a data transaction, then a stray ready.
        lat_fix = 50; d0 = d_obs;
        d_q.push_back(32'h300);
        for (int i = 0; i < 10 && m_who != 2; i++) cycle();
        cycle(); cycle();
        rst_pend = 1; cycle();
        stray_pend = 1; cycle();
        cycle();
        chk("rstmid_en", mem_rd_enable, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_d_ready", d_obs - d0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: one error pulse, no ready, back to idle.
        lat_fix = 1000; err_obs = 0; d0 = d_obs;
        d_q.push_back(32'h400);
        for (int i = 0; i < 14; i++) cycle();
        chk("to_err_pulses", err_obs, 1);
        chk("to_d_ready", d_obs - d0, 0);
        chk("to_busy", busy, 0);
`endif

        // Random traffic with random latency, stray readies and flushes.
        lat_fix = -1;
        for (int i = 0; i < 400; i++) begin
            if (f_q.size() == 0 && $urandom_range(0, 3) == 0) f_q.push_back($urandom);
            if (d_q.size() == 0 && $urandom_range(0, 3) == 0) d_q.push_back($urandom);
            if (m_who == 0 && $urandom_range(0, 7) == 0) stray_pend = 1;
            if ($urandom_range(0, 23) == 0) flush_pend = 1;
            cycle();
        end
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
